// File: rtl/cand_mem_arbiter_pkg.sv
// ============================================================================
// Module : cand_mem_arbiter_pkg
// Brief  : Shared constants and FSM encoding for the candidate memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cand_mem_arbiter_pkg;

    localparam int PACKET_WIDTH = 2048;
    localparam int ADDR_WIDTH   = 12;
    localparam int DEPTH        = 3600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SERVE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; grants the first request at or
//          after ptr, wrapping modulo N.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    // Scan from the farthest offset back to ptr so the closest request wins.
    always_comb begin
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                     = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cand_mem_arbiter.sv
// ============================================================================
// Module : cand_mem_arbiter
// Brief  : Sequences fill writes and round-robin reads on the single-port
//          candidate memory; responses return one cycle after the grant.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cand_mem_arbiter #(
    parameter int PACKET_WIDTH = cand_mem_arbiter_pkg::PACKET_WIDTH,
    parameter int ADDR_WIDTH   = cand_mem_arbiter_pkg::ADDR_WIDTH,
    parameter int DEPTH        = cand_mem_arbiter_pkg::DEPTH,
    parameter int NUM_RD       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fill_start,
    input  logic [ADDR_WIDTH-1:0]        fill_count,
    output logic                         fill_done,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [PACKET_WIDTH-1:0]      wr_data,
    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_gnt,
    output logic                         rd_valid,
    output logic [1:0]                   rd_id,
    output logic                         rd_err,
    output logic [PACKET_WIDTH-1:0]      rd_data,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [PACKET_WIDTH-1:0]      mem_wdata,
    input  logic [PACKET_WIDTH-1:0]      mem_rdata
);

    import cand_mem_arbiter_pkg::*;

    localparam int                    RR_W    = $clog2(NUM_RD);
    localparam logic [ADDR_WIDTH-1:0] c_depth = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_one   = ADDR_WIDTH'(1);

    state_t                r_state,     w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_remaining, w_remaining_nxt;
    logic [RR_W-1:0]       r_rr_ptr,    w_rr_ptr_nxt;
    logic                  r_fill_done, w_fill_done_nxt;
    logic                  r_rd_valid,  w_rd_valid_nxt;
    logic [1:0]            r_rd_id,     w_rd_id_nxt;
    logic                  r_rd_err,    w_rd_err_nxt;

    logic [NUM_RD-1:0]     w_gnt;
    logic [1:0]            w_gnt_idx;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [ADDR_WIDTH-1:0] w_fill_len;
    logic                  w_grant_en;

    rr_arbiter #(
        .N     (NUM_RD),
        .PTR_W (RR_W)
    ) u_rr_arbiter (
        .req (rd_req),
        .ptr (r_rr_ptr),
        .gnt (w_gnt)
    );

    assign w_fill_len = (fill_count > c_depth) ? c_depth : fill_count;

    always_comb begin
        w_gnt_idx  = '0;
        w_gnt_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = 2'(i);
                w_gnt_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_addr_nxt   = r_wr_addr;
        w_remaining_nxt = r_remaining;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_fill_done_nxt = 1'b0;
        w_rd_valid_nxt  = 1'b0;
        w_rd_id_nxt     = 2'd0;
        w_rd_err_nxt    = 1'b0;
        w_grant_en      = 1'b0;
        wr_ready        = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        rd_gnt          = '0;

        case (r_state)
            IDLE, SERVE: begin
                // fill_start takes priority over any pending read request.
                if (fill_start) begin
                    if (w_fill_len == '0) begin
                        w_fill_done_nxt = 1'b1;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_state_nxt     = FILL;
                        w_wr_addr_nxt   = '0;
                        w_remaining_nxt = w_fill_len;
                    end
                end else if (|rd_req) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = SERVE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_we          = 1'b1;
                    mem_addr        = r_wr_addr;
                    mem_wdata       = wr_data;
                    w_wr_addr_nxt   = r_wr_addr + c_one;
                    w_remaining_nxt = r_remaining - c_one;
                    if (r_remaining == c_one) begin
                        w_fill_done_nxt = 1'b1;
                        w_state_nxt     = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_grant_en) begin
            rd_gnt         = w_gnt;
            mem_addr       = w_gnt_addr;
            w_rd_valid_nxt = 1'b1;
            w_rd_id_nxt    = w_gnt_idx;
            w_rd_err_nxt   = (w_gnt_addr >= c_depth);
            w_rr_ptr_nxt   = (int'(w_gnt_idx) == NUM_RD - 1) ? '0 : RR_W'(w_gnt_idx + 2'd1);
        end

        // Keep the memory and requesters quiet while reset is held.
        if (!rst) begin
            wr_ready  = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            rd_gnt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wr_addr   <= '0;
            r_remaining <= '0;
            r_rr_ptr    <= '0;
            r_fill_done <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_id     <= 2'd0;
            r_rd_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_fill_done <= w_fill_done_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_id     <= w_rd_id_nxt;
            r_rd_err    <= w_rd_err_nxt;
        end
    end

    assign fill_done = r_fill_done;
    assign rd_valid  = r_rd_valid;
    assign rd_id     = r_rd_id;
    assign rd_err    = r_rd_err;
    assign rd_data   = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cand_mem_arbiter.sv
// ============================================================================
// Module : tb_cand_mem_arbiter
// Brief  : Directed self-checking bench for cand_mem_arbiter with a RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cand_mem_arbiter;

    localparam int PW = 2048;
    localparam int AW = 12;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          fill_start;
    logic [AW-1:0] fill_count;
    logic          fill_done;
    logic          wr_valid;
    logic          wr_ready;
    logic [PW-1:0] wr_data;
    logic [NR-1:0] rd_req;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0] rd_gnt;
    logic          rd_valid;
    logic [1:0]    rd_id;
    logic          rd_err;
    logic [PW-1:0] rd_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata;

    logic [PW-1:0] ram [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    cand_mem_arbiter #(
        .PACKET_WIDTH (PW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (3600),
        .NUM_RD       (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .fill_count (fill_count),
        .fill_done  (fill_done),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_id      (rd_id),
        .rd_err     (rd_err),
        .rd_data    (rd_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [PW-1:0] pkt(input logic [31:0] s);
        return {64{s}};
    endfunction

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input int n, input logic [31:0] base);
        fill_start = 1'b1;
        fill_count = AW'(n);
        #1;
        check("fill_start_no_we", PW'(mem_we), PW'(0));
        step();
        fill_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = pkt(base + 32'(i));
            #1;
            check("fill_ready", PW'(wr_ready), PW'(1));
            check("fill_we",    PW'(mem_we),   PW'(1));
            check("fill_addr",  PW'(mem_addr), PW'(i));
            check("fill_wdata", mem_wdata,     pkt(base + 32'(i)));
            check("fill_done_early", PW'(fill_done), PW'(0));
            step();
        end
        wr_valid = 1'b0;
        #1;
        check("fill_done_pulse", PW'(fill_done), PW'(1));
        check("fill_idle_ready", PW'(wr_ready),  PW'(0));
        step();
        check("fill_done_clear", PW'(fill_done), PW'(0));
    endtask

    initial begin
        rst        = 1'b0;
        fill_start = 1'b0;
        fill_count = '0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_req     = '0;
        rd_addr    = '0;
        step();
        step();
        check("rst_fill_done", PW'(fill_done), PW'(0));
        check("rst_wr_ready",  PW'(wr_ready),  PW'(0));
        check("rst_rd_valid",  PW'(rd_valid),  PW'(0));
        check("rst_rd_id",     PW'(rd_id),     PW'(0));
        check("rst_rd_err",    PW'(rd_err),    PW'(0));
        check("rst_mem_we",    PW'(mem_we),    PW'(0));
        check("rst_mem_addr",  PW'(mem_addr),  PW'(0));
        rst = 1'b1;

        // Reset in the middle of a fill of 10.
        fill_start = 1'b1;
        fill_count = 12'd10;
        step();
        fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = pkt(32'h1000 + 32'(i));
            #1;
            check("midfill_addr", PW'(mem_addr), PW'(i));
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("midfill_rst_ready", PW'(wr_ready),  PW'(0));
        check("midfill_rst_we",    PW'(mem_we),    PW'(0));
        check("midfill_rst_done",  PW'(fill_done), PW'(0));
        check("midfill_rst_valid", PW'(rd_valid),  PW'(0));
        wr_valid = 1'b0;
        step();
        do_fill(10, 32'h2000);

        // Fill A,B,C then read address 2 from requester 0.
        do_fill(3, 32'hA0);
        rd_req  = 2'b01;
        rd_addr = {12'd0, 12'd2};
        #1;
        check("rd2_gnt",  PW'(rd_gnt),   PW'(2'b01));
        check("rd2_addr", PW'(mem_addr), PW'(2));
        check("rd2_we",   PW'(mem_we),   PW'(0));
        step();
        rd_req = 2'b00;
        #1;
        check("rd2_valid", PW'(rd_valid), PW'(1));
        check("rd2_id",    PW'(rd_id),    PW'(0));
        check("rd2_err",   PW'(rd_err),   PW'(0));
        check("rd2_data",  rd_data,       pkt(32'hA2));
        step();
        check("rd2_valid_clear", PW'(rd_valid), PW'(0));

        // Requester 1 once so the pointer is back at 0, then round-robin.
        rd_req  = 2'b10;
        rd_addr = {12'd1, 12'd0};
        #1;
        check("rr_pre_gnt", PW'(rd_gnt), PW'(2'b10));
        step();
        rd_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_gnt", PW'(rd_gnt), (k % 2 == 0) ? PW'(2'b01) : PW'(2'b10));
            check("rr_prev_valid", PW'(rd_valid), PW'(1));
            check("rr_prev_id",    PW'(rd_id),    (k % 2 == 0) ? PW'(1) : PW'(0));
            check("rr_prev_data",  rd_data,       (k % 2 == 0) ? pkt(32'hA1) : pkt(32'hA0));
            step();
        end
        rd_req = 2'b00;
        #1;
        check("rr_last_id",   PW'(rd_id),  PW'(1));
        check("rr_last_data", rd_data,     pkt(32'hA1));
        check("rr_no_gnt",    PW'(rd_gnt), PW'(0));
        step();

        // Out-of-range (3600) then the last valid address (3599).
        rd_req  = 2'b01;
        rd_addr = {12'd0, 12'd3600};
        #1;
        check("oor_gnt", PW'(rd_gnt), PW'(2'b01));
        step();
        rd_req  = 2'b10;
        rd_addr = {12'd3599, 12'd0};
        #1;
        check("oor_valid", PW'(rd_valid), PW'(1));
        check("oor_err",   PW'(rd_err),   PW'(1));
        check("edge_gnt",  PW'(rd_gnt),   PW'(2'b10));
        step();
        rd_req = 2'b00;
        #1;
        check("edge_valid", PW'(rd_valid), PW'(1));
        check("edge_id",    PW'(rd_id),    PW'(1));
        check("edge_err",   PW'(rd_err),   PW'(0));
        step();

        // Fill preempts continuous reads.
        rd_req  = 2'b11;
        rd_addr = {12'd1, 12'd0};
        #1;
        check("pre_gnt", PW'(rd_gnt), PW'(2'b01));
        step();
        fill_start = 1'b1;
        fill_count = 12'd2;
        #1;
        check("pre_inflight_valid", PW'(rd_valid), PW'(1));
        check("pre_inflight_id",    PW'(rd_id),    PW'(0));
        check("pre_fs_no_gnt",      PW'(rd_gnt),   PW'(0));
        step();
        fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = pkt(32'hF0 + 32'(i));
            #1;
            check("pre_fill_no_gnt", PW'(rd_gnt),   PW'(0));
            check("pre_fill_we",     PW'(mem_we),   PW'(1));
            check("pre_fill_addr",   PW'(mem_addr), PW'(i));
            check("pre_fill_valid",  PW'(rd_valid), PW'(0));
            step();
        end
        wr_valid = 1'b0;
        #1;
        check("pre_done",       PW'(fill_done), PW'(1));
        check("pre_resume_gnt", PW'(rd_gnt),    PW'(2'b10));
        step();
        rd_req = 2'b00;
        #1;
        check("pre_resume_id",   PW'(rd_id), PW'(1));
        check("pre_resume_data", rd_data,    pkt(32'hF1));
        step();

        // Empty fill.
        fill_start = 1'b1;
        fill_count = 12'd0;
        #1;
        check("empty_we", PW'(mem_we), PW'(0));
        step();
        fill_start = 1'b0;
        #1;
        check("empty_done",  PW'(fill_done), PW'(1));
        check("empty_ready", PW'(wr_ready),  PW'(0));
        check("empty_we2",   PW'(mem_we),    PW'(0));
        step();
        check("empty_done_clear", PW'(fill_done), PW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cand_mem_arbiter.md
# cand_mem_arbiter

Sequences and shares the single-port candidate memory of the motion-estimation datapath. A fill phase streams reference packets from the loader into the memory. Outside fill, the block grants reads to NUM_RD search engines round-robin, one per cycle, and returns each packet with a requester tag one cycle later. It sits between the loader and search engines on one side and the 3600-entry, 8×256-bit candidate RAM on the other.

## Interface
Parameters:
- PACKET_WIDTH, 2048, candidate packet width (8 × DATA_WIDTH_256)
- ADDR_WIDTH, 12, memory address width
- DEPTH, 3600, valid entries; addresses ≥ DEPTH are out of range
- NUM_RD, 2, number of read requesters (2..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- fill_start  in  1  pulse: begin fill phase
- fill_count  in  ADDR_WIDTH  packets to write, sampled with fill_start
- fill_done  out  1  one-cycle pulse after the last fill write
- wr_valid  in  1  loader packet valid
- wr_ready  out  1  loader packet accepted
- wr_data  in  PACKET_WIDTH  loader packet
- rd_req  in  NUM_RD  per-requester read request, held until granted
- rd_addr  in  NUM_RD×ADDR_WIDTH  per-requester address; slice i belongs to requester i
- rd_gnt  out  NUM_RD  one-hot grant, same cycle as request
- rd_valid  out  1  read response valid
- rd_id  out  2  requester index of the response
- rd_err  out  1  response was for an out-of-range address; rd_data is undefined
- rd_data  out  PACKET_WIDTH  response packet
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  PACKET_WIDTH  RAM write data
- mem_rdata  in  PACKET_WIDTH  RAM read data, valid the cycle after the address is presented

## Operation
- FSM states: IDLE, FILL, SERVE.
- **Reset** (rst=0 at a clk edge):
  - state=IDLE, rr_ptr=0, fill counter=0.
  - All outputs 0: fill_done, wr_ready, rd_gnt, rd_valid, rd_id, rd_err, mem_we, mem_addr.
  - Reset mid-fill abandons the fill. Memory contents are not cleared.
- **IDLE**
  - fill_start goes to FILL, with wr_addr=0 and remaining=fill_count.
  - fill_count=0 does not enter FILL: fill_done pulses next cycle and the state stays IDLE.
  - Otherwise, any rd_req goes to SERVE; the first grant is issued in the same cycle.
- **FILL**
  - wr_ready=1 and rd_gnt=0.
  - On wr_valid: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data; wr_addr increments and remaining decrements.
  - When the write with remaining=1 is accepted, fill_done pulses the next cycle and the state returns to IDLE.
  - fill_start during FILL is ignored.
  - A fill_count above DEPTH is clamped to DEPTH.
- **SERVE**
  - Round-robin: grant the first requester at or after rr_ptr with rd_req=1. After a grant, rr_ptr = granted+1 mod NUM_RD.
  - Granted address drives mem_addr with mem_we=0.
  - Address ≥ DEPTH: still granted, but the response carries rd_err=1.
  - No requests: return to IDLE.
  - fill_start in SERVE: the in-flight response completes. Next cycle the state is FILL with no further grants; reads are held off until the fill ends.
- mem_wdata is driven only during FILL writes.

## Timing
- Grant is combinational from rd_req and rr_ptr: at most one grant per cycle, throughput 1 read per cycle.
- Read latency is 1: granted at edge N, response at edge N+1.
  - rd_valid, rd_id and rd_err are registered.
  - rd_data = mem_rdata, passed through unregistered.
- Write throughput is 1 packet per cycle while wr_valid is held.
- A requester holding rd_req after its grant is treated as issuing a new request.
- When fill_start and rd_req arrive in the same IDLE cycle, fill wins.

## Structure
- Shared package/constants file holds PACKET_WIDTH, ADDR_WIDTH, DEPTH and the FSM state encoding (IDLE=0, FILL=1, SERVE=2).
- One sub-module: rr_arbiter (parameter N; inputs req and ptr; output one-hot gnt), reusable by other schedulers.
- Estimated size: about 200 lines of RTL.

## Test plan
- **Reset mid-fill:** fill_count=10, assert rst=0 after 4 writes → next cycle all outputs 0 and state IDLE. A new fill of 10 then writes addresses 0..9.
- **Fill then read:** fill_count=3 with data A,B,C → mem_we high for 3 cycles at addresses 0,1,2; fill_done one cycle after the write of C. Then rd_req[0] at address 2 → rd_valid next cycle with rd_id=0 and rd_data=C.
- **Round-robin:** rd_req=2'b11 held for 4 cycles → grants 01,10,01,10; responses carry rd_id 0,1,0,1, each one cycle after its grant.
- **Out-of-range read:** rd_addr=3600 → granted; next cycle rd_valid=1, rd_err=1.
- **Fill preempting reads:** fill_start during continuous reads → the one in-flight response completes, then rd_gnt=0 for the whole fill. Reads resume after fill_done.
- **Empty fill:** fill_count=0 → fill_done pulse next cycle, no mem_we, state stays IDLE.
